// File: rtl/cont_mod_n.sv
// -----------------------------------------------------------------------------
// cont_mod_n : parametrised modulo-N up/down counter with terminal count
//
// Counts 0..MODULUS-1 in either direction. It has a count enable, a synchronous
// parallel load, and a combinational terminal-count output for building
// multi-digit chains. The default parameters give the classic mod-13
// up-counter.
//
// Parameters
//   WIDTH      bit width of y; must satisfy 2**WIDTH >= MODULUS
//   MODULUS    number of count states (2..2**WIDTH)
//
// Ports
//   clock       in   single clock, all state updates on its rising edge
//   reset       in   synchronous active-high reset (highest priority)
//   enable      in   count enable; load is honoured regardless
//   up          in   1 = increment, 0 = decrement
//   load        in   synchronous parallel load strobe
//   load_value  in   WIDTH-bit value to load (out-of-range loads give 0)
//   y           out  registered count value
//   tc          out  terminal count: the next enabled edge wraps
//   wraps       out  8-bit registered wrap counter (only with the macro)
//
// Optional feature
//   CONT_WRAP_COUNT_EN  when defined, adds the wraps output, which counts
//                       every wrap in either direction and rolls over
//                       from 255 to 0.
// -----------------------------------------------------------------------------
module cont_mod_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] y,
`ifdef CONT_WRAP_COUNT_EN
    output logic [7:0]       wraps,
`endif
    output logic             tc
);

    // Highest legal count value. When MODULUS == 2**WIDTH this is all ones,
    // and the explicit compare-and-wrap coincides with natural overflow.
    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] y_next;
    logic             at_top;
    logic             at_bottom;
    logic             load_in_range;
    logic             wrap_now;

    assign at_top    = (y_reg == TOP_VAL);
    assign at_bottom = (y_reg == '0);

    // Compare at 32 bits so that MODULUS == 2**WIDTH does not overflow the
    // comparison constant.
    assign load_in_range = (32'(load_value) < 32'(MODULUS));

    // Terminal count depends only on the current inputs and state. A pending
    // load suppresses it because the load overrides the count on that edge.
    assign wrap_now = (up & at_top) | (~up & at_bottom);
    assign tc       = enable & ~load & wrap_now;

    // Next-state selection below reset: load > enable > hold.
    always_comb begin
        y_next = y_reg;
        if (load) begin
            y_next = load_in_range ? load_value : '0;
        end else if (enable) begin
            if (up) begin
                y_next = at_top ? '0 : (y_reg + ONE);
            end else begin
                y_next = at_bottom ? TOP_VAL : (y_reg - ONE);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            y_reg <= '0;
        end else begin
            y_reg <= y_next;
        end
    end

    assign y = y_reg;

`ifdef CONT_WRAP_COUNT_EN
    logic [7:0] wraps_reg;

    // tc already excludes load cycles, so loads never bump the wrap count.
    // Natural 8-bit overflow gives the silent 255 -> 0 rollover.
    always_ff @(posedge clock) begin
        if (reset) begin
            wraps_reg <= 8'd0;
        end else if (tc) begin
            wraps_reg <= wraps_reg + 8'd1;
        end
    end

    assign wraps = wraps_reg;
`endif

endmodule

// File: tb/tb_cont_mod_n.sv
module tb_cont_mod_n;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 13;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] y;
    logic             tc;

    // Cascade pair: stage 2 is enabled by stage 1's terminal count.
    logic             c_reset;
    logic             c_enable;
    logic [WIDTH-1:0] lo_y;
    logic [WIDTH-1:0] hi_y;
    logic             lo_tc;
    logic             hi_tc;
    logic [WIDTH-1:0] zero_lv = '0;

`ifdef CONT_WRAP_COUNT_EN
    logic [7:0] wraps;
    logic [7:0] lo_wraps;
    logic [7:0] hi_wraps;
`endif

    int checks = 0;
    int passed = 0;

    // Reference model state: the count as a plain integer and the number of
    // wraps seen modulo 256.
    int m_y     = 0;
    int m_wraps = 0;

    always #5 clock = ~clock;

    cont_mod_n #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .y          (y),
`ifdef CONT_WRAP_COUNT_EN
        .wraps      (wraps),
`endif
        .tc         (tc)
    );

    cont_mod_n #(.WIDTH(WIDTH), .MODULUS(MODULUS)) stage_lo (
        .clock      (clock),
        .reset      (c_reset),
        .enable     (c_enable),
        .up         (1'b1),
        .load       (1'b0),
        .load_value (zero_lv),
        .y          (lo_y),
`ifdef CONT_WRAP_COUNT_EN
        .wraps      (lo_wraps),
`endif
        .tc         (lo_tc)
    );

    cont_mod_n #(.WIDTH(WIDTH), .MODULUS(MODULUS)) stage_hi (
        .clock      (clock),
        .reset      (c_reset),
        .enable     (lo_tc),
        .up         (1'b1),
        .load       (1'b0),
        .load_value (zero_lv),
        .y          (hi_y),
`ifdef CONT_WRAP_COUNT_EN
        .wraps      (hi_wraps),
`endif
        .tc         (hi_tc)
    );

    // Model tc: the next enabled, non-load edge would cross the 0 / MODULUS-1
    // boundary in the current direction.
    function automatic logic model_tc();
        if (!enable || load) return 1'b0;
        if (up) return (m_y + 1 == MODULUS);
        return (m_y == 0);
    endfunction

    // Drive inputs just after the falling edge, then let combinational
    // outputs settle.
    task automatic set_inputs(input logic r, input logic e, input logic u,
                              input logic l, input logic [WIDTH-1:0] lv);
        @(negedge clock);
        reset      = r;
        enable     = e;
        up         = u;
        load       = l;
        load_value = lv;
        #1;
    endtask

    // Advance one rising edge and update the model from the inputs that
    // were applied at that edge.
    task automatic clock_edge();
        logic wrap;
        wrap = model_tc() && !reset;
        if (reset) begin
            m_y     = 0;
            m_wraps = 0;
        end else if (load) begin
            m_y = (int'(load_value) < MODULUS) ? int'(load_value) : 0;
        end else if (enable) begin
            m_y = up ? (m_y + 1) % MODULUS : (m_y + MODULUS - 1) % MODULUS;
            if (wrap) m_wraps = (m_wraps + 1) % 256;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        clock_edge();
        set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        checks++;
        if (y !== 4'd0) $display("FAIL reset_y: got %0d expected 0", y);
        else passed++;
        checks++;
        if (tc !== 1'b0) $display("FAIL reset_tc: got %b expected 0", tc);
        else passed++;
`ifdef CONT_WRAP_COUNT_EN
        checks++;
        if (wraps !== 8'd0) $display("FAIL reset_wraps: got %0d expected 0", wraps);
        else passed++;
`endif
        $display("test_reset: y=%0d tc=%b", y, tc);
    endtask

    task automatic test_count_up();
        set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        clock_edge();
        for (int i = 0; i < 14; i++) begin
            set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            checks++;
            if (int'(y) !== i % MODULUS) $display("FAIL up_y[%0d]: got %0d expected %0d", i, y, i % MODULUS);
            else passed++;
            checks++;
            if (tc !== (i == 12)) $display("FAIL up_tc[%0d]: got %b expected %b", i, tc, (i == 12));
            else passed++;
            $display("count_up %0d: y=%0d tc=%b", i, y, tc);
            clock_edge();
        end
        checks++;
        if (y !== 4'd1) $display("FAIL up_final: got %0d expected 1", y);
        else passed++;
`ifdef CONT_WRAP_COUNT_EN
        checks++;
        if (wraps !== 8'd1) $display("FAIL up_wraps: got %0d expected 1", wraps);
        else passed++;
`endif
    endtask

    task automatic test_count_down();
        int exp_y [3] = '{12, 11, 10};
        set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        clock_edge();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            checks++;
            if (tc !== (i == 0)) $display("FAIL down_tc[%0d]: got %b expected %b", i, tc, (i == 0));
            else passed++;
            clock_edge();
            checks++;
            if (int'(y) !== exp_y[i]) $display("FAIL down_y[%0d]: got %0d expected %0d", i, y, exp_y[i]);
            else passed++;
            $display("count_down %0d: y=%0d", i, y);
        end
    endtask

    task automatic test_load();
        set_inputs(1'b0, 1'b0, 1'b1, 1'b1, 4'd7);
        checks++;
        if (tc !== 1'b0) $display("FAIL load_tc_a: got %b expected 0", tc);
        else passed++;
        clock_edge();
        checks++;
        if (y !== 4'd7) $display("FAIL load_7: got %0d expected 7", y);
        else passed++;
        set_inputs(1'b0, 1'b0, 1'b1, 1'b1, 4'd14);
        checks++;
        if (tc !== 1'b0) $display("FAIL load_tc_b: got %b expected 0", tc);
        else passed++;
        clock_edge();
        checks++;
        if (y !== 4'd0) $display("FAIL load_oor: got %0d expected 0", y);
        else passed++;
        $display("test_load: y=%0d after out-of-range load", y);
    endtask

    task automatic test_priority();
        int w0;
        set_inputs(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
        clock_edge();
        set_inputs(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        clock_edge();
        checks++;
        if (y !== 4'd0) $display("FAIL prio_reset: got %0d expected 0", y);
        else passed++;
        set_inputs(1'b0, 1'b0, 1'b1, 1'b1, 4'd12);
        clock_edge();
        w0 = m_wraps;
        set_inputs(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
        checks++;
        if (tc !== 1'b0) $display("FAIL prio_load_tc: got %b expected 0", tc);
        else passed++;
        clock_edge();
        checks++;
        if (y !== 4'd3) $display("FAIL prio_load_y: got %0d expected 3", y);
        else passed++;
`ifdef CONT_WRAP_COUNT_EN
        checks++;
        if (int'(wraps) !== w0) $display("FAIL prio_wraps: got %0d expected %0d", wraps, w0);
        else passed++;
`endif
        $display("test_priority: y=%0d model_wraps=%0d", y, w0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_inputs(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            checks++;
            if (tc !== model_tc()) $display("FAIL rand_tc[%0d]: got %b expected %b", i, tc, model_tc());
            else passed++;
            clock_edge();
            checks++;
            if (int'(y) !== m_y) $display("FAIL rand_y[%0d]: got %0d expected %0d", i, y, m_y);
            else passed++;
`ifdef CONT_WRAP_COUNT_EN
            checks++;
            if (int'(wraps) !== m_wraps) $display("FAIL rand_wraps[%0d]: got %0d expected %0d", i, wraps, m_wraps);
            else passed++;
`endif
            $display("rand %0d: r=%b e=%b u=%b l=%b lv=%0d y=%0d", i, reset, enable, up, load, load_value, y);
        end
    endtask

    task automatic test_cascade();
        int hi_steps = 0;
        logic [WIDTH-1:0] hi_prev;
        @(negedge clock);
        c_reset  = 1'b1;
        c_enable = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        c_reset = 1'b0;
        hi_prev = hi_y;
        for (int k = 0; k < 169; k++) begin
            @(posedge clock);
            #1;
            if (hi_y !== hi_prev) hi_steps++;
            hi_prev = hi_y;
            checks++;
            if (int'(lo_y) !== (k + 1) % 13 || int'(hi_y) !== ((k + 1) / 13) % 13)
                $display("FAIL cascade[%0d]: got lo=%0d hi=%0d expected lo=%0d hi=%0d",
                         k, lo_y, hi_y, (k + 1) % 13, ((k + 1) / 13) % 13);
            else passed++;
        end
        checks++;
        if (lo_y !== 4'd0 || hi_y !== 4'd0) $display("FAIL cascade_end: got lo=%0d hi=%0d expected 0 0", lo_y, hi_y);
        else passed++;
        checks++;
        if (hi_steps !== 13) $display("FAIL cascade_steps: got %0d expected 13", hi_steps);
        else passed++;
        $display("test_cascade: lo=%0d hi=%0d hi_steps=%0d", lo_y, hi_y, hi_steps);
        @(negedge clock);
        c_enable = 1'b0;
    endtask

    task automatic test_hold_and_wraps();
        int y0;
        int w0;
        set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        clock_edge();
`ifdef CONT_WRAP_COUNT_EN
        for (int i = 0; i < 256 * MODULUS; i++) begin
            set_inputs(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
            clock_edge();
            if (i == MODULUS - 1) begin
                checks++;
                if (wraps !== 8'd1) $display("FAIL wraps_first: got %0d expected 1", wraps);
                else passed++;
            end
        end
        checks++;
        if (wraps !== 8'd0 || y !== 4'd0) $display("FAIL wraps_roll: got wraps=%0d y=%0d expected 0 0", wraps, y);
        else passed++;
        $display("wraps after 256 wraps: %0d", wraps);
`endif
        for (int i = 0; i < 5; i++) begin
            set_inputs(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
            clock_edge();
        end
        y0 = m_y;
        w0 = m_wraps;
        for (int i = 0; i < 10; i++) begin
            set_inputs(1'b0, 1'b0, 1'($urandom), 1'b0, 4'($urandom));
            clock_edge();
            checks++;
            if (int'(y) !== y0) $display("FAIL hold_y[%0d]: got %0d expected %0d", i, y, y0);
            else passed++;
`ifdef CONT_WRAP_COUNT_EN
            checks++;
            if (int'(wraps) !== w0) $display("FAIL hold_wraps[%0d]: got %0d expected %0d", i, wraps, w0);
            else passed++;
`endif
        end
        $display("test_hold: y=%0d held for 10 cycles (model wraps %0d)", y, w0);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        up         = 1'b1;
        load       = 1'b0;
        load_value = '0;
        c_reset    = 1'b1;
        c_enable   = 1'b0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_priority();
        test_random();
        test_cascade();
        test_hold_and_wraps();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
